wr_resp_mem: RTL and testbench
==============================

Name: wr_resp_mem

Overview:
Write-responder end of the addr/dat/wr_en write interface: a synchronous 256x16 storage target that commits initiator writes and returns them on a one-cycle-latency read port. It also enforces the no-consecutive-same-address write rule in hardware, flagging any write whose address equals the previous committed-or-attempted write's address. It sits as the target behind any block that drives the write interface.

Parameters:
ADDR_W, 8, address width; storage depth is 2**ADDR_W
DATA_W, 16, data word width
CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  single clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe, sampled at posedge clk
addr  in  ADDR_W  write address, valid when wr_en=1
dat  in  DATA_W  write data, valid when wr_en=1
wr_ack  out  1  one-cycle pulse the cycle after a committed write
rd_req  in  1  read request, sampled at posedge clk
rd_addr  in  ADDR_W  read address
rd_valid  out  1  pulse one cycle after rd_req
rd_data  out  DATA_W  read data, valid when rd_valid=1, holds otherwise
consec_err  out  1  one-cycle pulse the cycle after an offending write
err_sticky  out  1  set on any offending write, cleared by err_clr
err_cnt  out  CNT_W  saturating count of offending writes
err_clr  in  1  synchronous clear of err_sticky and err_cnt

Behaviour:
- Reset (rst_n=0, async): wr_ack=0, rd_valid=0, rd_data=0, consec_err=0, err_sticky=0, err_cnt=0, prev_vld=0, prev_addr=0. Storage array is not reset.
- Write: at a posedge with wr_en=1, mem[addr]<=dat (subject to Optional Feature); wr_ack=1 in the following cycle only.
- Hazard tracking: prev_addr/prev_vld hold the address of the most recent wr_en=1 cycle. Any number of idle (wr_en=0) cycles may separate two writes. Idle cycles never clear prev_vld.
- Offending write: wr_en=1 and prev_vld=1 and addr==prev_addr. Then:
  - consec_err=1 in the next cycle.
  - err_sticky<=1.
  - err_cnt increments, saturating at 2**CNT_W-1.
  - prev_addr is updated on every wr_en=1 cycle, offending or not.
- Back-to-back wr_en=1 cycles are legal; each is checked against the immediately preceding write.
- First write after reset is never offending (prev_vld=0).
- err_clr:
  - err_clr=1 with no offending write in the same cycle: err_cnt<=0, err_sticky<=0.
  - err_clr=1 with an offending write in the same cycle: the error wins; err_cnt<=1, err_sticky<=1, consec_err pulses.
- Read: rd_req=1 at posedge N gives rd_valid=1 and rd_data=mem[rd_addr] at N+1. Back-to-back reads are fully pipelined.
- Simultaneous read and write to the same address: read returns the old data (read-before-write).
- rd_data holds its last value when rd_valid=0.
- Reset asserted mid-operation: all outputs return to their reset values immediately. An in-flight read is lost, with no rd_valid. Storage contents are undefined-but-unchanged.

Optional Feature:
- Macro: WR_RESP_DROP_CONSEC_EN.
- Defined: an offending write is not committed to storage and wr_ack is not pulsed for it. consec_err, err_sticky, err_cnt and prev_addr update exactly as above.
- Undefined: an offending write is committed and acked normally; it is flagged only.

Decomposition:
- Package wr_resp_pkg holds:
  - localparams ADDR_W=8, DATA_W=16, CNT_W=8
  - typedefs addr_t, data_t, cnt_t
- Sub-module consec_wr_chk holds prev_addr/prev_vld, offending-write detection, the consec_err pulse, the sticky flag and the saturating counter. It outputs a combinational "offend" signal so the top level can gate the commit.
- The top level holds storage, the read pipeline and wr_ack.

Test Plan:
- Reset, write 10/100, idle cycle, write 12/200, read 10 and 12: wr_ack pulses twice; rd_data=100 then 200; consec_err never asserts; err_cnt=0.
- Write 10/111, idle, write 10/222: consec_err pulses one cycle after the second write; err_sticky=1; err_cnt=1. Read 10 returns 222 without the macro, or 111 with WR_RESP_DROP_CONSEC_EN (and no second wr_ack).
- Same-cycle write 5/0xAAAA and read 5 after mem[5]=0x1111: rd_data=0x1111; a following read returns 0xAAAA.
- Write addr 3 repeatedly for 300 consecutive cycles: err_cnt saturates at 255. Then err_clr with no write: err_cnt=0, err_sticky=0.
- err_clr in the same cycle as an offending write to 7 (after a prior write to 7): err_cnt=1, err_sticky=1.
- Sequence:
  - Write 20, then pulse rst_n low mid-read.
  - Release reset and write 20 again.
  - Required: all outputs are 0 during reset, the aborted read gives no rd_valid, and the write after reset raises no consec_err (prev_vld cleared).

Source files
------------

// File: rtl/wr_resp_pkg.sv
// Shared widths, types and helpers for the wr_resp_mem write-responder slice.
package wr_resp_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

  function automatic cnt_t sat_inc(input cnt_t c);
    cnt_t r;
    if (c != CNT_MAX) begin
      r = c + cnt_t'(1);
    end else begin
      r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/wr_resp_mem_if.sv
// Write and read bus between an initiator (master) and the wr_resp_mem target (slave).
interface wr_resp_mem_if;
  import wr_resp_pkg::*;

  logic  wr_en;
  addr_t addr;
  data_t dat;
  logic  wr_ack;
  logic  rd_req;
  addr_t rd_addr;
  logic  rd_valid;
  data_t rd_data;

  modport master (
    output wr_en, addr, dat, rd_req, rd_addr,
    input  wr_ack, rd_valid, rd_data
  );

  modport slave (
    input  wr_en, addr, dat, rd_req, rd_addr,
    output wr_ack, rd_valid, rd_data
  );

endinterface

// File: rtl/wr_resp_mem_consec_wr_chk.sv
// Flags writes that repeat the previous write address; keeps sticky flag and saturating count.
module consec_wr_chk
  import wr_resp_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  addr_t addr,
  input  logic  err_clr,
  output logic  offend,
  output logic  consec_err,
  output logic  err_sticky,
  output cnt_t  err_cnt
);

  logic  prev_vld_q, prev_vld_d;
  addr_t prev_addr_q, prev_addr_d;
  logic  consec_err_q, consec_err_d;
  logic  err_sticky_q, err_sticky_d;
  cnt_t  err_cnt_q, err_cnt_d;

  // Detection and next-state for hazard tracking and error bookkeeping.
  always_comb begin
    offend       = wr_en & prev_vld_q & (addr == prev_addr_q);
    prev_vld_d   = prev_vld_q;
    prev_addr_d  = prev_addr_q;
    consec_err_d = offend;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;

    if (wr_en) begin
      prev_vld_d  = 1'b1;
      prev_addr_d = addr;
    end else begin
      prev_vld_d  = prev_vld_q;
      prev_addr_d = prev_addr_q;
    end

    // A same-cycle clear loses to a new error: the count restarts at one.
    if (offend) begin
      err_sticky_d = 1'b1;
      if (err_clr) begin
        err_cnt_d = cnt_t'(1);
      end else begin
        err_cnt_d = sat_inc(err_cnt_q);
      end
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end else begin
      err_sticky_d = err_sticky_q;
      err_cnt_d    = err_cnt_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vld_q   <= 1'b0;
      prev_addr_q  <= '0;
      consec_err_q <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      prev_vld_q   <= prev_vld_d;
      prev_addr_q  <= prev_addr_d;
      consec_err_q <= consec_err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign consec_err = consec_err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: rtl/wr_resp_mem.sv
// Write-responder storage target with one-cycle read port and consecutive-address checking.
// Define WR_RESP_DROP_CONSEC_EN to discard (and not ack) offending writes.
module wr_resp_mem
  import wr_resp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  wr_resp_mem_if.slave bus,
  input  logic         err_clr,
  output logic         consec_err,
  output logic         err_sticky,
  output cnt_t         err_cnt
);

`ifdef WR_RESP_DROP_CONSEC_EN
  localparam logic DROP_CONSEC = 1'b1;
`else
  localparam logic DROP_CONSEC = 1'b0;
`endif

  localparam int unsigned DEPTH = 1 << ADDR_W;

  data_t mem [DEPTH];

  logic  offend;
  logic  commit;
  logic  wr_ack_q, wr_ack_d;
  logic  rd_valid_q, rd_valid_d;
  data_t rd_data_q, rd_data_d;

  consec_wr_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (bus.wr_en),
    .addr       (bus.addr),
    .err_clr    (err_clr),
    .offend     (offend),
    .consec_err (consec_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  assign commit = bus.wr_en & ~(DROP_CONSEC & offend);

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[bus.addr] <= bus.dat;
    end
  end

  // Ack and read pipeline next-state; the array read sees pre-write contents.
  always_comb begin
    wr_ack_d   = commit;
    rd_valid_d = bus.rd_req;
    rd_data_d  = rd_data_q;
    if (bus.rd_req) begin
      rd_data_d = mem[bus.rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.wr_ack   = wr_ack_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_wr_resp_mem.sv
// Self-checking bench for wr_resp_mem: directed plan plus randomized traffic vs. a behavioural model.
module tb_wr_resp_mem;
  import wr_resp_pkg::*;

`ifdef WR_RESP_DROP_CONSEC_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic err_clr;
  logic consec_err;
  logic err_sticky;
  cnt_t err_cnt;

  wr_resp_mem_if bus();

  wr_resp_mem dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_clr    (err_clr),
    .consec_err (consec_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int mm [256];
  bit m_prev_vld;
  int m_prev_addr;
  bit m_sticky;
  int m_cnt;
  int m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_vld  = 1'b0;
    m_prev_addr = 0;
    m_sticky    = 1'b0;
    m_cnt       = 0;
    m_rd        = 0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, ".wr_ack"},     32'(bus.wr_ack),   32'd0);
    check({tag, ".rd_valid"},   32'(bus.rd_valid), 32'd0);
    check({tag, ".rd_data"},    32'(bus.rd_data),  32'd0);
    check({tag, ".consec_err"}, 32'(consec_err),   32'd0);
    check({tag, ".err_sticky"}, 32'(err_sticky),   32'd0);
    check({tag, ".err_cnt"},    32'(err_cnt),      32'd0);
  endtask

  // One clock: apply inputs, predict, then compare every output after the edge.
  task automatic step(input bit we, input int a, input int d,
                      input bit rr, input int ra, input bit clr);
    bit off;
    bit com;
    bus.wr_en   = we;
    bus.addr    = addr_t'(a);
    bus.dat     = data_t'(d);
    bus.rd_req  = rr;
    bus.rd_addr = addr_t'(ra);
    err_clr     = clr;

    off = we && m_prev_vld && (a == m_prev_addr);
    com = we && !(DROP && off);
    if (rr) m_rd = mm[ra];
    if (off) begin
      m_sticky = 1'b1;
      m_cnt    = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
    end
    if (we) begin
      m_prev_vld  = 1'b1;
      m_prev_addr = a;
    end
    if (com) mm[a] = d;

    @(posedge clk);
    #1;
    check("wr_ack",     32'(bus.wr_ack),   32'(com));
    check("rd_valid",   32'(bus.rd_valid), 32'(rr));
    check("rd_data",    32'(bus.rd_data),  32'(m_rd));
    check("consec_err", 32'(consec_err),   32'(off));
    check("err_sticky", 32'(err_sticky),   32'(m_sticky));
    check("err_cnt",    32'(err_cnt),      32'(m_cnt));

    bus.wr_en  = 1'b0;
    bus.rd_req = 1'b0;
    err_clr    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    err_clr     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.addr    = '0;
    bus.dat     = '0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    model_reset();
    #12;
    check_reset_outs("por");
    #1 rst_n = 1'b1;

    // Fill storage with known values (incrementing addresses never collide)
    for (int i = 0; i < 256; i++) step(1'b1, i, int'($urandom_range(0, 65535)), 1'b0, 0, 1'b0);

    // Reset pulse between edges; storage must survive it
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst1");
    #2 rst_n = 1'b1;
    model_reset();

    // Plan 1: distinct writes and read-back
    step(1'b1, 10, 100, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 0, 1'b0);
    step(1'b1, 12, 200, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 10, 1'b0);
    step(1'b0, 0, 0, 1'b1, 12, 1'b0);
    check("plan1.rd12", 32'(bus.rd_data), 32'd200);

    // Plan 2: same address across an idle cycle
    step(1'b1, 10, 111, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 0, 1'b0);
    step(1'b1, 10, 222, 1'b0, 0, 1'b0);
    check("plan2.cnt", 32'(err_cnt), 32'd1);
    step(1'b0, 0, 0, 1'b1, 10, 1'b0);
    check("plan2.rd10", 32'(bus.rd_data), DROP ? 32'd111 : 32'd222);

    // Plan 3: read-before-write on the same address
    step(1'b1, 5, 16'h1111, 1'b0, 0, 1'b0);
    step(1'b1, 6, 16'h2222, 1'b0, 0, 1'b0);
    step(1'b1, 5, 16'hAAAA, 1'b1, 5, 1'b0);
    check("plan3.old", 32'(bus.rd_data), 32'h1111);
    step(1'b0, 0, 0, 1'b1, 5, 1'b0);
    check("plan3.new", 32'(bus.rd_data), 32'hAAAA);

    // Plan 4: saturate the counter, then clear
    for (int i = 0; i < 300; i++) step(1'b1, 3, i, 1'b0, 0, 1'b0);
    check("plan4.sat", 32'(err_cnt), 32'd255);
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    check("plan4.clr", 32'(err_cnt), 32'd0);

    // Plan 5: clear collides with an offending write
    step(1'b1, 7, 1, 1'b0, 0, 1'b0);
    step(1'b1, 7, 2, 1'b0, 0, 1'b1);
    check("plan5.cnt", 32'(err_cnt), 32'd1);
    check("plan5.sticky", 32'(err_sticky), 32'd1);

    // Plan 6: reset during an in-flight read
    step(1'b1, 20, 16'h5A5A, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 20, 1'b0);
    bus.rd_req  = 1'b1;
    bus.rd_addr = addr_t'(20);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst2.async");
    @(posedge clk);
    #1 check_reset_outs("rst2.held");
    bus.rd_req = 1'b0;
    #3 rst_n = 1'b1;
    model_reset();
    step(1'b1, 20, 16'h0F0F, 1'b0, 0, 1'b0);
    check("plan6.nohaz", 32'(consec_err), 32'd0);

    // Randomized traffic over a narrow address window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
